// File: rtl/countdown_timer.sv
// countdown_timer: multi-digit BCD down-counter with an internal prescaler.
// A value is loaded (digits clamped to 9), counting starts on START, PAUSE
// freezes both the prescaler phase and the count, and the block parks in
// EXPIRED once the count reaches zero. Borrows ripple combinationally.
module countdown_timer #(
  parameter int DIGITS   = 3,
  parameter int PRESCALE = 50000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  pause,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick,
  output logic                  running,
  output logic                  done
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  logic [1:0]          state_reg, state_next;
  logic [4*DIGITS-1:0] count_reg, count_next;
  logic [PW-1:0]       presc_reg, presc_next;
  logic                tick_reg, tick_next;
  logic                running_reg, done_reg;

  logic [4*DIGITS-1:0] load_clamped;
  logic [4*DIGITS-1:0] dec_val;
  logic [DIGITS-1:0]   borrow;
  logic                count_zero;
  logic                dec_zero;

  // Per-digit clamp of the preset and one-step BCD decrement with borrow chain.
  // borrow[i] means digit i must decrement; digit 0 always does.
  assign borrow[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] ld_digit;
      logic [3:0] cur_digit;

      assign ld_digit  = load_val[4*gi +: 4];
      assign cur_digit = count_reg[4*gi +: 4];

      assign load_clamped[4*gi +: 4] = (ld_digit > 4'd9) ? 4'd9 : ld_digit;

      assign dec_val[4*gi +: 4] = !borrow[gi]          ? cur_digit :
                                  (cur_digit == 4'd0)  ? 4'd9      :
                                                         cur_digit - 4'd1;

      if (gi < DIGITS - 1) begin : g_borrow
        assign borrow[gi+1] = borrow[gi] & (cur_digit == 4'd0);
      end
    end
  endgenerate

  assign count_zero = (count_reg == '0);
  assign dec_zero   = (dec_val == '0);

  // Next-state logic: LOAD overrides everything, then per-state handling.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    presc_next = presc_reg;
    tick_next  = 1'b0;
    if (load) begin
      count_next = load_clamped;
      presc_next = '0;
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_next = count_zero ? ST_EXPIRED : ST_RUN;
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_next = ST_HOLD;
          end else if (presc_reg == PS_LAST) begin
            presc_next = '0;
            count_next = dec_val;
            tick_next  = 1'b1;
            if (dec_zero) begin
              state_next = ST_EXPIRED;
            end
          end else begin
            presc_next = presc_reg + PW'(1);
          end
        end
        ST_HOLD: begin
          // Phase is frozen; resuming continues from the same prescaler value.
          if (!pause) begin
            state_next = ST_RUN;
          end
        end
        ST_EXPIRED: begin
          state_next = ST_EXPIRED;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // State, count, prescaler and registered status flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      count_reg   <= '0;
      presc_reg   <= '0;
      tick_reg    <= 1'b0;
      running_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      presc_reg   <= presc_next;
      tick_reg    <= tick_next;
      running_reg <= (state_next == ST_RUN);
      done_reg    <= (state_next == ST_EXPIRED);
    end
  end

  assign count   = count_reg;
  assign tick    = tick_reg;
  assign running = running_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed scenarios plus randomized traffic, all checked
// against a decimal-arithmetic reference model of the timer.
module tb_countdown_timer;

  localparam int DIGITS   = 3;
  localparam int PRESCALE = 4;
  localparam int W        = 4 * DIGITS;

  logic         clock;
  logic         reset;
  logic         load;
  logic [W-1:0] load_val;
  logic         start;
  logic         pause;
  logic [W-1:0] count;
  logic         tick;
  logic         running;
  logic         done;

  int n_checks;
  int n_errors;

  // reference model: value kept as a plain integer, mode as a small code
  int m_val;
  int m_phase;
  int m_mode;   // 0 idle, 1 counting, 2 held, 3 expired
  bit m_tick;
  int tick_seen;

  countdown_timer #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .pause    (pause),
    .count    (count),
    .tick     (tick),
    .running  (running),
    .done     (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int bcd_to_int(input logic [W-1:0] v);
    int r = 0;
    int scale = 1;
    for (int i = 0; i < DIGITS; i++) begin
      int d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      r += d * scale;
      scale *= 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] int_to_bcd(input int v);
    logic [W-1:0] r = '0;
    int x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic void model_reset();
    m_val   = 0;
    m_phase = 0;
    m_mode  = 0;
    m_tick  = 1'b0;
  endfunction

  function automatic void model_step(input bit ld, input logic [W-1:0] lv, input bit st, input bit pz);
    m_tick = 1'b0;
    if (ld) begin
      m_val   = bcd_to_int(lv);
      m_phase = 0;
      m_mode  = 0;
    end else begin
      case (m_mode)
        0: if (st) m_mode = (m_val != 0) ? 1 : 3;
        1: begin
          if (pz) m_mode = 2;
          else if (m_phase == PRESCALE - 1) begin
            m_phase = 0;
            m_val   = m_val - 1;
            m_tick  = 1'b1;
            if (m_val == 0) m_mode = 3;
          end else m_phase++;
        end
        2: if (!pz) m_mode = 1;
        default: ;
      endcase
    end
  endfunction

  task automatic compare_all(input string tag);
    check_eq({tag, ".count"},   32'(count),   32'(int_to_bcd(m_val)));
    check_eq({tag, ".tick"},    32'(tick),    32'(m_tick));
    check_eq({tag, ".running"}, 32'(running), 32'(m_mode == 1));
    check_eq({tag, ".done"},    32'(done),    32'(m_mode == 3));
  endtask

  // One clock with the given inputs; outputs sampled 1 time unit after the edge.
  task automatic do_cycle(input string tag, input bit ld, input logic [W-1:0] lv,
                          input bit st, input bit pz);
    load = ld; load_val = lv; start = st; pause = pz;
    @(posedge clock);
    model_step(ld, lv, st, pz);
    #1;
    if (tick) tick_seen++;
    compare_all(tag);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; tick_seen = 0;
    load = 0; load_val = '0; start = 0; pause = 0;
    reset = 1'b0;
    model_reset();
    #12;
    compare_all("reset");
    reset = 1'b1;
    #1;

    // 1: count down from 105, crossing a two-digit borrow
    do_cycle("t1.load", 1, 12'h105, 0, 0);
    do_cycle("t1.start", 0, '0, 1, 0);
    tick_seen = 0;
    for (int i = 0; i < 6 * PRESCALE; i++) do_cycle("t1.run", 0, '0, 0, 0);
    check_eq("t1.final_count", 32'(count), 32'h099);
    check_eq("t1.tick_count", 32'(tick_seen), 32'd6);
    $display("txn t1: load 0x105 + start, count now 0x%0h, ticks %0d", count, tick_seen);

    // 2: run to zero; DONE with the final tick, further START ignored
    do_cycle("t2.load", 1, 12'h002, 0, 0);
    do_cycle("t2.start", 0, '0, 1, 0);
    for (int i = 0; i < 2 * PRESCALE; i++) do_cycle("t2.run", 0, '0, 0, 0);
    check_eq("t2.done", 32'(done), 32'd1);
    do_cycle("t2.restart", 0, '0, 1, 0);
    check_eq("t2.zero_after_start", 32'(count), 32'h000);
    $display("txn t2: 0x002 expired, done=%0b count=0x%0h", done, count);

    // 3: pause two cycles into a prescaler period, hold ten, resume
    do_cycle("t3.load", 1, 12'h050, 0, 0);
    do_cycle("t3.start", 0, '0, 1, 0);
    do_cycle("t3.ph1", 0, '0, 0, 0);
    do_cycle("t3.ph2", 0, '0, 0, 0);
    tick_seen = 0;
    for (int i = 0; i < 10; i++) do_cycle("t3.hold", 0, '0, 0, 1);
    check_eq("t3.no_tick_in_hold", 32'(tick_seen), 32'd0);
    check_eq("t3.held_count", 32'(count), 32'h050);
    do_cycle("t3.release", 0, '0, 0, 0);
    do_cycle("t3.resume1", 0, '0, 0, 0);
    check_eq("t3.no_early_tick", 32'(tick), 32'd0);
    do_cycle("t3.resume2", 0, '0, 0, 0);
    check_eq("t3.tick_after_2", 32'(tick), 32'd1);
    $display("txn t3: pause/resume, count now 0x%0h", count);

    // 4: clamped load, LOAD beats START
    do_cycle("t4.load", 1, 12'hA3F, 0, 0);
    check_eq("t4.clamp", 32'(count), 32'h939);
    do_cycle("t4.load_start", 1, 12'h123, 1, 0);
    check_eq("t4.stay_idle", 32'(running), 32'd0);
    $display("txn t4: clamp 0xA3F -> 0x939, load+start idle");

    // 5: start at zero expires without a tick; reload leaves EXPIRED
    tick_seen = 0;
    do_cycle("t5.load0", 1, 12'h000, 0, 0);
    do_cycle("t5.start", 0, '0, 1, 0);
    check_eq("t5.done", 32'(done), 32'd1);
    check_eq("t5.no_tick", 32'(tick_seen), 32'd0);
    do_cycle("t5.reload", 1, 12'h010, 0, 0);
    check_eq("t5.done_clear", 32'(done), 32'd0);
    $display("txn t5: zero start expired, reload 0x010");

    // 6: asynchronous reset in the middle of a run
    do_cycle("t6.load", 1, 12'h037, 0, 0);
    do_cycle("t6.start", 0, '0, 1, 0);
    for (int i = 0; i < 6; i++) do_cycle("t6.run", 0, '0, 0, 0);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_eq("t6.async_count", 32'(count), 32'h000);
    check_eq("t6.async_running", 32'(running), 32'd0);
    compare_all("t6.async");
    #2;
    reset = 1'b1;
    do_cycle("t6.start_after", 0, '0, 1, 0);
    check_eq("t6.rejected", 32'(done), 32'd1);
    $display("txn t6: async reset mid-run, restart rejected");

    // random traffic
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 60; i++) begin
        bit ld = ($urandom_range(0, 99) < 4);
        bit st = ($urandom_range(0, 99) < 25);
        bit pz = ($urandom_range(0, 99) < 15);
        logic [W-1:0] lv = ($urandom_range(0, 1) == 0) ? W'($urandom) : W'($urandom_range(0, 21));
        do_cycle("rand", ld, lv, st, pz);
      end
      $display("txn rand burst %0d: count=0x%0h running=%0b done=%0b", b, count, running, done);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
